// File: rtl/conv1x1_channel_feeder.sv
// Packs a serial channel stream into LANES-wide words, two pixel banks
// (ping-pong), and replays each pixel as one contiguous framed burst
// followed by at least one idle cycle.
module conv1x1_channel_feeder #(
    parameter int DATWIDTH     = 16,
    parameter int INPUTCHANNEL = 64,
    parameter int LANES        = 16,
    parameter int INPUTSIZE    = 55
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DATWIDTH-1:0]       s_data,
    input  logic                      i_hold,
    output logic                      o_data_valid,
    output logic [LANES*DATWIDTH-1:0] imgdata,
    output logic                      firstvalue,
    output logic                      lastvalue,
    output logic                      o_frame_done
);

    localparam int G      = INPUTCHANNEL / LANES;
    localparam int GRP_W  = (G > 1) ? $clog2(G) : 1;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int NPIX   = INPUTSIZE * INPUTSIZE;
    localparam int PIX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [GRP_W-1:0]  GRP_LAST  = GRP_W'(G - 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);
    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(NPIX - 1);

    typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

    logic [LANES*DATWIDTH-1:0] mem [0:1][0:G-1];

    state_t             state, state_n;
    logic [GRP_W-1:0]   beat, beat_n;
    logic [LANE_W-1:0]  lane_cnt, lane_n;
    logic [GRP_W-1:0]   grp_cnt, grp_n;
    logic               wptr, wptr_n, rptr, rptr_n;
    logic [1:0]         full, full_n;
    logic [PIX_W-1:0]   pix, pix_n;
    logic               accept, last_ch, free;
    logic               emit, last_beat, frame_end;

    assign accept  = s_valid && s_ready;
    assign last_ch = accept && (lane_cnt == LANE_LAST) && (grp_cnt == GRP_LAST);

    // Read-side burst sequencing: launch only on a full bank with no hold, never break a burst
    always_comb begin
        state_n = state;
        beat_n  = beat;
        free    = 1'b0;
        unique case (state)
            IDLE: begin
                if (full[rptr] && !i_hold) begin
                    state_n = BURST;
                    beat_n  = '0;
                end
            end
            BURST: begin
                if (beat == GRP_LAST) begin
                    state_n = GAP;
                    free    = 1'b1;
                end else begin
                    beat_n = beat + 1'b1;
                end
            end
            GAP: begin
                // The gap cycle doubles as the idle check, so back-to-back pixels get one idle cycle
                if (full[rptr] && !i_hold) begin
                    state_n = BURST;
                    beat_n  = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Bank bookkeeping: write counters, bank fill/free and pointer toggles
    always_comb begin
        lane_n = lane_cnt;
        grp_n  = grp_cnt;
        wptr_n = wptr;
        rptr_n = rptr;
        full_n = full;
        if (accept) begin
            if (lane_cnt == LANE_LAST) begin
                lane_n = '0;
                grp_n  = (grp_cnt == GRP_LAST) ? '0 : grp_cnt + 1'b1;
            end else begin
                lane_n = lane_cnt + 1'b1;
            end
        end
        if (last_ch) begin
            full_n[wptr] = 1'b1;
            wptr_n       = ~wptr;
        end
        if (free) begin
            full_n[rptr] = 1'b0;
            rptr_n       = ~rptr;
        end
    end

    assign emit      = (state_n == BURST);
    assign last_beat = emit && (beat_n == GRP_LAST);
    assign frame_end = last_beat && (pix == PIX_LAST);

    // Pixel position in the frame advances on every burst's final beat
    always_comb begin
        pix_n = pix;
        if (last_beat) begin
            pix_n = frame_end ? '0 : pix + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= state_n;
            beat  <= beat_n;
        end
    end

    // Write-side control and bank flags; s_ready follows the next-state fill of the next write bank
    always_ff @(posedge clk) begin
        if (!rst) begin
            lane_cnt <= '0;
            grp_cnt  <= '0;
            wptr     <= 1'b0;
            rptr     <= 1'b0;
            full     <= 2'b00;
            pix      <= '0;
            s_ready  <= 1'b0;
        end else begin
            lane_cnt <= lane_n;
            grp_cnt  <= grp_n;
            wptr     <= wptr_n;
            rptr     <= rptr_n;
            full     <= full_n;
            pix      <= pix_n;
            s_ready  <= !full_n[wptr_n];
        end
    end

    // Bank storage: each accepted value lands in its lane of the current word
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (accept && (lane_cnt == LANE_W'(k))) begin
                mem[wptr][grp_cnt][k*DATWIDTH +: DATWIDTH] <= s_data;
            end
        end
    end

    // Registered outputs; data and framing are forced to zero outside a burst
    always_ff @(posedge clk) begin
        if (!rst) begin
            o_data_valid <= 1'b0;
            imgdata      <= '0;
            firstvalue   <= 1'b0;
            lastvalue    <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_data_valid <= emit;
            imgdata      <= emit ? mem[rptr][beat_n] : '0;
            firstvalue   <= emit && (beat_n == '0);
            lastvalue    <= last_beat;
            o_frame_done <= frame_end;
        end
    end

endmodule
